// File: rtl/kicker_pkg.sv
// Shared types and helpers for the multi-channel solenoid kicker controller.
// No logic or storage of its own; imported by kicker_ctrl and kicker_timer.
package kicker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    COOL = 2'd2
  } state_t;

  // Index width for done_ch; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Limit the requested pulse length to the capacitor-safe maximum.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/kicker_timer.sv
// Loadable down-counter shared by the FIRE and COOL phases; value updates one cycle after load/dec.
// No backpressure: load wins over dec, and last flags the final cycle of a loaded interval.
module kicker_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= value - 1'b1;
    end
  end

  assign last = (value == CNT_W'(1));

endmodule

// File: rtl/kicker_ctrl.sv
// Multi-channel kicker: one shot at a time, clamped pulse, mandatory cooldown; kick one cycle after the request edge.
// No backpressure: request edges arriving while busy, or beyond the lowest-index winner, are dropped with a reject pulse.
module kicker_ctrl
  import kicker_pkg::*;
#(
  parameter int          NCH       = 2,
  parameter int          CNT_W     = 16,
  parameter int unsigned MAX_PULSE = 5000,
  parameter int unsigned COOLDOWN  = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NCH-1:0]             req,
  input  logic [CNT_W-1:0]           pulse_len,
  input  logic                       abort,
  output logic [NCH-1:0]             kick,
  output logic                       busy,
  output logic                       done,
  output logic [ch_width(NCH)-1:0]   done_ch,
  output logic                       reject,
  output logic                       aborted
);

  localparam int              CHW      = ch_width(NCH);
  localparam logic [CNT_W-1:0] COOL_VAL = CNT_W'(COOLDOWN);

  state_t           state;
  logic [NCH-1:0]   prev_req;
  logic [NCH-1:0]   ev;
  logic [NCH-1:0]   sel_oh;
  logic [CHW-1:0]   sel;
  logic [CHW-1:0]   ch;
  logic             found;
  logic             extra;
  logic [CNT_W-1:0] len_c;

  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_last;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;

  // Events only exist while armed; disarmed edges vanish without a reject.
  assign ev    = req & ~prev_req & {NCH{enable}};
  assign len_c = CNT_W'(clamp_len(32'(pulse_len), MAX_PULSE));

  always_comb begin
    found  = 1'b0;
    sel    = '0;
    sel_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ev[i] && !found) begin
        found     = 1'b1;
        sel       = CHW'(i);
        sel_oh[i] = 1'b1;
      end
    end
    extra = |(ev & ~sel_oh);
  end

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = COOL_VAL;
    tmr_dec      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && len_c != '0) begin
          tmr_load     = 1'b1;
          tmr_load_val = len_c;
        end
      end
      FIRE: begin
        if (abort || tmr_last) tmr_load = 1'b1;
        else                   tmr_dec  = 1'b1;
      end
      COOL:    tmr_dec = (tmr_value != '0);
      default: tmr_dec = 1'b0;
    endcase
  end

  kicker_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .last     (tmr_last)
  );

  // All-ones prev_req after reset keeps a request held across reset from firing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prev_req <= '1;
      ch       <= '0;
      kick     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_ch  <= '0;
      reject   <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      prev_req <= req;
      done     <= 1'b0;
      aborted  <= 1'b0;
      reject   <= 1'b0;
      unique case (state)
        IDLE: begin
          reject <= extra || (found && len_c == '0);
          if (found && len_c != '0) begin
            state <= FIRE;
            ch    <= sel;
            kick  <= sel_oh;
            busy  <= 1'b1;
          end
        end
        FIRE: begin
          reject <= |ev;
          if (abort) begin
            state   <= COOL;
            kick    <= '0;
            aborted <= 1'b1;
            done_ch <= ch;
          end else if (tmr_last) begin
            state   <= COOL;
            kick    <= '0;
            done    <= 1'b1;
            done_ch <= ch;
          end
        end
        COOL: begin
          reject <= |ev;
          if (tmr_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          kick  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
